// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the pipeline hazard controller: shadow entries,
// memory-wait FSM states and the register-index width.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned REG_W = 4;

    localparam int unsigned SH_EX    = 0;
    localparam int unsigned SH_MEM   = 1;
    localparam int unsigned SH_WB    = 2;
    localparam int unsigned SH_DEPTH = 3;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             wbEn;
        logic             memRead;
    } shadow_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } mem_state_e;

    function automatic logic dest_match(
        input shadow_t          e,
        input logic             use1,
        input logic [REG_W-1:0] src1,
        input logic             use2,
        input logic [REG_W-1:0] src2
    );
        return e.valid & e.wbEn &
               ((use1 & (src1 == e.dest)) | (use2 & (src2 == e.dest)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / bubble / flush / freeze sequencing for the 5-stage pipeline, decided
// from a registered shadow of the EX, MEM and WB writeback info.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             forward_En,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_src1,
    input  logic [REG_W-1:0] id_src2,
    input  logic             id_use_src1,
    input  logic             id_use_src2,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_wbEn,
    input  logic             id_memRead,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             hazard_stall,
    output logic             flush,
    output logic             freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int unsigned    WAIT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    shadow_t          pipe_q [SH_DEPTH];
    shadow_t          pipe_d [SH_DEPTH];
    mem_state_e       state_q;
    mem_state_e       state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic             timeout_q;
    logic             timeout_d;

    logic match_ex;
    logic match_mem;
    logic hazard;
    logic freeze_c;
    logic flush_c;
    logic stall_c;

    // WB is deliberately not matched: the register file writes in the first half-cycle.
    assign match_ex  = id_valid & dest_match(pipe_q[SH_EX],  id_use_src1, id_src1,
                                             id_use_src2, id_src2);
    assign match_mem = id_valid & dest_match(pipe_q[SH_MEM], id_use_src1, id_src1,
                                             id_use_src2, id_src2);

    assign hazard = forward_En ? (match_ex & pipe_q[SH_EX].memRead)
                               : (match_ex | match_mem);

    // Gating by rst_n keeps every output low while reset is asserted.
    assign freeze_c = rst_n & mem_req & ~mem_ready;
    assign flush_c  = rst_n & branch_taken & ~freeze_c;
    assign stall_c  = rst_n & hazard & ~flush_c & ~freeze_c;

    assign freeze       = freeze_c;
    assign flush        = flush_c;
    assign hazard_stall = stall_c;
    assign mem_timeout  = timeout_q;

    always_comb begin
        for (int unsigned i = 0; i < SH_DEPTH; i++) begin
            pipe_d[i] = pipe_q[i];
        end
        if (!freeze_c) begin
            pipe_d[SH_WB]  = pipe_q[SH_MEM];
            pipe_d[SH_MEM] = pipe_q[SH_EX];
            if (flush_c || stall_c) begin
                pipe_d[SH_EX] = '0;
            end else begin
                pipe_d[SH_EX] = '{valid: id_valid, dest: id_dest,
                                  wbEn: id_wbEn, memRead: id_memRead};
            end
        end
    end

    // The wait counter parks at its last value once the sticky flag is due.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_IDLE: begin
                if (freeze_c) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
                if (mem_ready || !mem_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SH_DEPTH; i++) begin
                pipe_q[i] <= '0;
            end
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < SH_DEPTH; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_c),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (freeze_c),
        .count (freeze_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scenario and randomized checks of pipeline_hazard_ctrl against an in-flight
// instruction list model; narrow counters so saturation is reached.
module tb_pipeline_hazard_ctrl;

    localparam int TO   = 64;
    localparam int W    = 4;
    localparam int MAXC = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic forward_En, id_valid, id_use_src1, id_use_src2, id_wbEn, id_memRead;
    logic [3:0] id_src1, id_src2, id_dest;
    logic branch_taken, mem_req, mem_ready;
    logic hazard_stall, flush, freeze, mem_timeout;
    logic [W-1:0] stall_cnt, freeze_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(W)) dut (
        .clk(clk), .rst_n(rst_n), .forward_En(forward_En), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src1(id_use_src1),
        .id_use_src2(id_use_src2), .id_dest(id_dest), .id_wbEn(id_wbEn),
        .id_memRead(id_memRead), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .hazard_stall(hazard_stall), .flush(flush),
        .freeze(freeze), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt),
        .freeze_cnt(freeze_cnt)
    );

    // Reference model: list of in-flight instructions, index 0 = youngest (EX).
    typedef struct { bit v; int d; bit w; bit l; } ent_t;
    ent_t flight[$];
    bit m_wait, m_to;
    int m_waited, m_scnt, m_fcnt;
    bit e_freeze, e_flush, e_stall;

    function automatic bit reads(int k);
        return flight[k].v && flight[k].w && id_valid &&
               ((id_use_src1 && int'(id_src1) == flight[k].d) ||
                (id_use_src2 && int'(id_src2) == flight[k].d));
    endfunction

    task automatic model_reset();
        ent_t empty = '{v: 0, d: 0, w: 0, l: 0};
        flight.delete();
        repeat (3) flight.push_back(empty);
        m_wait = 0; m_to = 0; m_waited = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic model_eval();
        bit hz;
        e_freeze = rst_n && mem_req && !mem_ready;
        e_flush  = rst_n && branch_taken && !e_freeze;
        hz = forward_En ? (reads(0) && flight[0].l) : (reads(0) || reads(1));
        e_stall  = rst_n && hz && !e_flush && !e_freeze;
    endtask

    task automatic model_clock();
        ent_t n;
        if (e_stall && m_scnt < MAXC) m_scnt++;
        if (e_freeze && m_fcnt < MAXC) m_fcnt++;
        if (m_wait) begin
            m_waited++;
            if (m_waited >= TO) m_to = 1;
            if (!e_freeze) m_wait = 0;
        end else if (e_freeze) begin
            m_wait = 1;
            m_waited = 0;
        end
        if (!e_freeze) begin
            if (e_flush || e_stall) n = '{v: 0, d: 0, w: 0, l: 0};
            else n = '{v: id_valid, d: int'(id_dest), w: id_wbEn, l: id_memRead};
            flight.push_front(n);
            void'(flight.pop_back());
        end
    endtask

    // Inputs change at posedge+1; outputs are sampled at posedge+4.
    task automatic settle();
        #3;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_use_src2 = 0;
        id_dest = 0; id_wbEn = 0; id_memRead = 0;
        branch_taken = 0; mem_req = 0; mem_ready = 1;
    endtask

    task automatic set_id(input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                          input logic u2, input logic [3:0] d, input logic wb,
                          input logic ld);
        id_valid = 1; id_src1 = s1; id_use_src1 = u1; id_src2 = s2; id_use_src2 = u2;
        id_dest = d; id_wbEn = wb; id_memRead = ld;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        model_reset();
        branch_taken = 1; mem_req = 1; mem_ready = 0;
        #2;
        checks++; if (freeze !== 1'b0) begin errors++; $display("FAIL rst_freeze got %b exp 0", freeze); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", flush); end
        apply_reset();
        settle();
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b exp 0", hazard_stall); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got %b exp 0", mem_timeout); end
        checks++; if (stall_cnt !== '0 || freeze_cnt !== '0) begin errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", stall_cnt, freeze_cnt); end
        advance();
    endtask

    task automatic test_load_use();
        apply_reset();
        forward_En = 1;
        set_id(4'd0, 0, 4'd0, 0, 4'd3, 1, 1);            // LDR R3
        settle();
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_c0 got %b exp 0", hazard_stall); end
        advance();
        set_id(4'd3, 1, 4'd5, 1, 4'd4, 1, 0);            // ADD R4,R3,R5
        settle();
        checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", hazard_stall); end
        advance();
        settle();
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_release got %b exp 0", hazard_stall); end
        checks++; if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
        advance();
    endtask

    task automatic test_no_forward();
        apply_reset();
        forward_En = 0;
        set_id(4'd1, 1, 4'd1, 1, 4'd2, 1, 0);            // ADD R2
        settle();
        advance();
        set_id(4'd2, 1, 4'd1, 1, 4'd6, 1, 0);            // SUB R6,R2,R1
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if (hazard_stall !== (i < 2)) begin
                errors++; $display("FAIL nf_stall cyc%0d got %b exp %b", i, hazard_stall, i < 2);
            end
            advance();
        end
        settle();
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL nf_cnt got %0d exp 2", stall_cnt); end
        advance();
    endtask

    task automatic test_branch_vs_stall();
        apply_reset();
        forward_En = 1;
        set_id(4'd0, 0, 4'd0, 0, 4'd3, 1, 1);            // LDR R3
        settle();
        advance();
        set_id(4'd3, 1, 4'd0, 0, 4'd7, 1, 1);            // LDR R7,[R3] with branch
        branch_taken = 1;
        settle();
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL bs_flush got %b exp 1", flush); end
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL bs_stall got %b exp 0", hazard_stall); end
        advance();
        branch_taken = 0;
        set_id(4'd7, 1, 4'd0, 0, 4'd8, 1, 0);            // reader of flushed R7
        settle();
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL bs_bubble got %b exp 0", hazard_stall); end
        advance();
    endtask

    task automatic test_mem_wait();
        apply_reset();
        forward_En = 1;
        set_id(4'd0, 0, 4'd0, 0, 4'd3, 1, 1);            // LDR R3
        settle();
        advance();
        set_id(4'd3, 1, 4'd0, 0, 4'd4, 1, 0);
        branch_taken = 1; mem_req = 1; mem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            settle();
            checks++; if (freeze !== 1'b1) begin errors++; $display("FAIL mw_freeze cyc%0d got %b exp 1", i, freeze); end
            checks++; if (flush !== 1'b0 || hazard_stall !== 1'b0) begin
                errors++; $display("FAIL mw_masked cyc%0d got %b%b exp 00", i, flush, hazard_stall);
            end
            advance();
        end
        mem_ready = 1;
        settle();
        checks++; if (freeze !== 1'b0 || flush !== 1'b1) begin
            errors++; $display("FAIL mw_release got fr=%b fl=%b exp fr=0 fl=1", freeze, flush);
        end
        advance();
        idle_inputs();
        settle();
        checks++; if (freeze_cnt !== 4'd5) begin errors++; $display("FAIL mw_cnt got %0d exp 5", freeze_cnt); end
        advance();
    endtask

    task automatic hold_wait(input string tag, input int n);
        mem_req = 1; mem_ready = 0;
        for (int i = 0; i < n; i++) begin
            settle();
            checks++;
            if (mem_timeout !== m_to) begin
                errors++; $display("FAIL %s cyc%0d got %b exp %b", tag, i, mem_timeout, m_to);
            end
            advance();
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        hold_wait("to_a", TO + 2);
        settle();
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_set got %b exp 1", mem_timeout); end
        advance();
        mem_req = 0; mem_ready = 1;
        repeat (3) advance();
        settle();
        checks++; if (mem_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky got %b exp 1", mem_timeout); end
        mem_req = 1; mem_ready = 0;
        #1 rst_n = 0;
        model_reset();
        #1;
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_rst got %b exp 0", mem_timeout); end
        @(posedge clk);
        #1 rst_n = 1;
        hold_wait("to_b", TO + 2);
        mem_req = 0; mem_ready = 1;
        advance();
    endtask

    task automatic test_async_reset();
        apply_reset();
        forward_En = 0;
        set_id(4'd1, 1, 4'd0, 0, 4'd2, 1, 0);            // ADD R2
        settle();
        advance();
        set_id(4'd2, 1, 4'd0, 0, 4'd6, 1, 0);
        settle();
        advance();
        settle();
        checks++; if (hazard_stall !== 1'b1 || stall_cnt !== 4'd1) begin
            errors++; $display("FAIL ar_pre got st=%b cnt=%0d exp st=1 cnt=1", hazard_stall, stall_cnt);
        end
        branch_taken = 1; mem_req = 1; mem_ready = 0;
        #1 rst_n = 0;
        model_reset();
        #1;
        checks++; if ({hazard_stall, flush, freeze, mem_timeout} !== 4'b0) begin
            errors++; $display("FAIL ar_outs got %b exp 0000", {hazard_stall, flush, freeze, mem_timeout});
        end
        checks++; if (stall_cnt !== '0 || freeze_cnt !== '0) begin
            errors++; $display("FAIL ar_cnt got %0d/%0d exp 0/0", stall_cnt, freeze_cnt);
        end
        @(posedge clk);
        #1 rst_n = 1;
        branch_taken = 0; mem_req = 0; mem_ready = 1;
        settle();
        checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL ar_empty got %b exp 0", hazard_stall); end
        advance();
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            if (c % 60 == 0) forward_En = $urandom_range(0, 1);
            id_valid     = ($urandom_range(0, 9) < 8);
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            id_use_src1  = $urandom_range(0, 1);
            id_use_src2  = $urandom_range(0, 1);
            id_dest      = 4'($urandom_range(0, 3));
            id_wbEn      = ($urandom_range(0, 9) < 7);
            id_memRead   = ($urandom_range(0, 9) < 3);
            branch_taken = ($urandom_range(0, 9) == 0);
            mem_req      = ($urandom_range(0, 9) < 3);
            mem_ready    = ($urandom_range(0, 9) < 6);
            settle();
            checks++; if (hazard_stall !== e_stall) begin errors++; $display("FAIL rnd_stall c%0d got %b exp %b", c, hazard_stall, e_stall); end
            checks++; if (flush !== e_flush) begin errors++; $display("FAIL rnd_flush c%0d got %b exp %b", c, flush, e_flush); end
            checks++; if (freeze !== e_freeze) begin errors++; $display("FAIL rnd_freeze c%0d got %b exp %b", c, freeze, e_freeze); end
            checks++; if (mem_timeout !== m_to) begin errors++; $display("FAIL rnd_timeout c%0d got %b exp %b", c, mem_timeout, m_to); end
            checks++; if (stall_cnt !== W'(m_scnt)) begin errors++; $display("FAIL rnd_scnt c%0d got %0d exp %0d", c, stall_cnt, m_scnt); end
            checks++; if (freeze_cnt !== W'(m_fcnt)) begin errors++; $display("FAIL rnd_fcnt c%0d got %0d exp %0d", c, freeze_cnt, m_fcnt); end
            advance();
        end
    endtask

    initial begin
        rst_n = 0;
        forward_En = 1;
        idle_inputs();
        model_reset();
        #1;
        test_reset();
        test_load_use();
        test_no_forward();
        test_branch_vs_stall();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage pipeline around the forwarding datapath: stall, bubble, flush and freeze decisions.
- Keeps an internal shadow of the writeback info of in-flight instructions (EX, MEM, WB), so hazards are decided from its own registered state.
- Detects RAW hazards the forwarding muxes cannot cover, flushes on a taken branch, and freezes the whole pipeline while the data memory is not ready.
- Sits beside the ID stage; its outputs drive the PC, IF/ID, ID/EX and all pipeline-register enables.

Parameters:
- MEM_TIMEOUT, 64: WAIT cycles after which mem_timeout is flagged.
- CNT_W, 16: width of the saturating performance counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- forward_En  in  1  forwarding enabled (1) or disabled (0).
- id_valid  in  1  ID holds a real instruction.
- id_src1, id_src2  in  4 each  ID source registers.
- id_use_src1, id_use_src2  in  1 each  the source is actually read.
- id_dest  in  4  ID destination register.
- id_wbEn  in  1  ID instruction writes the register file.
- id_memRead  in  1  ID instruction is a load.
- branch_taken  in  1  taken branch resolved in EX.
- mem_req  in  1  MEM stage is issuing a load or store this cycle.
- mem_ready  in  1  data memory completes this cycle.
- hazard_stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX.
- flush  out  1  clear IF/ID and ID/EX.
- freeze  out  1  hold every pipeline register and the PC.
- mem_timeout  out  1  sticky error flag.
- stall_cnt  out  CNT_W  count of stall cycles.
- freeze_cnt  out  CNT_W  count of freeze cycles.

Behaviour:
- Shadow pipeline:
  - Three entries ex, mem, wb, each holding {valid, dest, wbEn, memRead}.
  - Reset: all entries invalid.
  - Advance on each clock edge where freeze=0:
    - wb<=mem, mem<=ex.
    - ex<=bubble (valid=0) if flush or hazard_stall.
    - Otherwise ex<={id_valid, id_dest, id_wbEn, id_memRead}.
  - freeze=1: all entries hold.
- Matching:
  - match_X = X.valid & X.wbEn & ((id_use_src1 & id_src1==X.dest) | (id_use_src2 & id_src2==X.dest)).
  - Only evaluated when id_valid=1.
- Hazard rule:
  - forward_En=1: hazard = match_ex & ex.memRead (load-use only, exactly 1 stall cycle).
  - forward_En=0: hazard = match_ex | match_mem.
  - The register file writes in the first half-cycle, so a WB-stage writer is never a hazard.
- Priority, highest first:
  - freeze = mem_req & ~mem_ready.
  - flush = branch_taken & ~freeze. A branch seen during freeze is flushed on the first unfrozen cycle, since EX holds.
  - hazard_stall = hazard & ~flush & ~freeze.
- Memory FSM (states IDLE and WAIT):
  - IDLE->WAIT when freeze=1.
  - WAIT->IDLE when mem_ready=1 or mem_req=0.
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches MEM_TIMEOUT-1 while still in WAIT, set mem_timeout.
  - mem_timeout is cleared only by reset; the FSM keeps waiting.
- Counters:
  - stall_cnt increments each cycle hazard_stall=1.
  - freeze_cnt increments each cycle freeze=1.
  - Both saturate at all-ones.
- Reset (rst_n low, asynchronous):
  - All state clears: shadow invalid, FSM IDLE, counters 0, mem_timeout 0.
  - All outputs are forced to 0 while rst_n=0, including the combinational freeze.
  - Reset mid-WAIT returns the FSM to IDLE; the pending access is abandoned.
- Latency: all outputs are combinational from registered shadow/FSM state plus current-cycle inputs; no pipeline delay.

Decomposition:
- Shared package:
  - Shadow entry struct {valid, dest[3:0], wbEn, memRead}.
  - FSM state enum {IDLE, WAIT}.
  - Register-index width constant, 4.
- One natural sub-module: sat_counter (parameter CNT_W; ports clk, rst_n, inc, count), instantiated twice.

Test Plan:
- Load-use, forward_En=1: LDR R3 then ADD R4,R3,R5 -> hazard_stall=1 for exactly 1 cycle; ex becomes bubble; stall_cnt=1.
- No forwarding, forward_En=0: ADD R2 then SUB R6,R2,R1 -> hazard_stall=1 for 2 cycles; the third back-to-back R2 reader sees no stall.
- Branch versus stall: branch_taken=1 in the same cycle as a load-use hazard -> flush=1, hazard_stall=0; next cycle ex invalid.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles, with branch_taken=1 held -> freeze=1 for 5 cycles, flush=0 throughout, shadow unchanged; flush=1 on the cycle mem_ready=1 arrives; freeze_cnt=5.
- Timeout: mem_ready held 0 for 64 cycles -> mem_timeout rises after 64 WAIT cycles and stays high; rst_n pulse clears it and returns the FSM to IDLE.
- Asynchronous reset mid-stall: rst_n low between clock edges -> all outputs 0 immediately and counters 0; after release, an empty shadow gives no spurious stall.
